stream_demux_1to2: RTL and testbench

Registered 1-to-2 demultiplexer with valid/ready handshakes. It steers each incoming word to output port 0 or port 1 according to a per-word select bit, and is the distribution counterpart of the 2-to-1 source mux (`Mux2NToN`) in the datapath. Each output has a one-entry holding register, so backpressure on one port never corrupts the other. A wrapping transfer counter per port supports bench and debug visibility.

---
 rtl/stream_pkg.sv | 10 +
 rtl/stream_slot.sv | 50 +++++
 rtl/stream_demux_1to2.sv | 89 ++++++++
 tb/tb_stream_demux_1to2.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared constants for the stream demux: default widths and select encodings.
package stream_pkg;

    localparam int unsigned DEFAULT_N       = 32;
    localparam int unsigned DEFAULT_COUNT_W = 8;

    localparam logic PORT_ZERO = 1'b0;
    localparam logic PORT_ONE  = 1'b1;

endpackage

// File: rtl/stream_slot.sv
// One-entry output holding register with full flag and valid/ready handshake.
module stream_slot #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wrEn,
    input  logic [N-1:0] wrData,
    output logic         outValid,
    output logic [N-1:0] outData,
    input  logic         outReady,
    output logic         canAccept
);

    logic         full_q, full_d;
    logic [N-1:0] data_q, data_d;
    logic         handshake;

    // Handshake and acceptance: a slot being drained this cycle can take a new word.
    always_comb begin
        handshake = full_q && outReady;
        canAccept = !full_q || outReady;
        outValid  = full_q;
        outData   = data_q;
    end

    // Next state: a write wins over a drain so back-to-back words keep the slot full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wrEn) begin
            full_d = 1'b1;
            data_d = wrData;
        end else if (handshake) begin
            full_d = 1'b0;
        end
    end

    // Slot register, cleared asynchronously so in-flight words are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demux: steers each word to port 0 or 1 by its select bit,
// with an independent holding slot and wrapping handshake counter per port.
module stream_demux_1to2
    import stream_pkg::*;
#(
    parameter int unsigned N       = DEFAULT_N,
    parameter int unsigned COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       inData,
    input  logic               inSelect,
    input  logic               inValid,
    output logic               inReady,
    output logic [N-1:0]       zeroData,
    output logic               zeroValid,
    input  logic               zeroReady,
    output logic [N-1:0]       oneData,
    output logic               oneValid,
    input  logic               oneReady,
    output logic [COUNT_W-1:0] zeroCount,
    output logic [COUNT_W-1:0] oneCount
);

    logic               zero_can_accept, one_can_accept;
    logic               zero_wr_en, one_wr_en;
    logic [COUNT_W-1:0] zero_count_q, zero_count_d;
    logic [COUNT_W-1:0] one_count_q, one_count_d;

    // Ready looks only at the selected port, so a stalled port never blocks the other.
    always_comb begin
        inReady    = (inSelect == PORT_ONE) ? one_can_accept : zero_can_accept;
        zero_wr_en = inValid && inReady && (inSelect == PORT_ZERO);
        one_wr_en  = inValid && inReady && (inSelect == PORT_ONE);
    end

    stream_slot #(
        .N (N)
    ) u_slot_zero (
        .clk       (clk),
        .rst       (rst),
        .wrEn      (zero_wr_en),
        .wrData    (inData),
        .outValid  (zeroValid),
        .outData   (zeroData),
        .outReady  (zeroReady),
        .canAccept (zero_can_accept)
    );

    stream_slot #(
        .N (N)
    ) u_slot_one (
        .clk       (clk),
        .rst       (rst),
        .wrEn      (one_wr_en),
        .wrData    (inData),
        .outValid  (oneValid),
        .outData   (oneData),
        .outReady  (oneReady),
        .canAccept (one_can_accept)
    );

    // Per-port counters advance on each output handshake and wrap freely.
    always_comb begin
        zero_count_d = zero_count_q;
        one_count_d  = one_count_q;
        if (zeroValid && zeroReady) begin
            zero_count_d = zero_count_q + 1'b1;
        end
        if (oneValid && oneReady) begin
            one_count_d = one_count_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_count_q <= '0;
            one_count_q  <= '0;
        end else begin
            zero_count_q <= zero_count_d;
            one_count_q  <= one_count_d;
        end
    end

    assign zeroCount = zero_count_q;
    assign oneCount  = one_count_q;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2 with a per-port scoreboard of expected words.
module tb_stream_demux_1to2;

    localparam int unsigned N       = 32;
    localparam int unsigned COUNT_W = 4;

    logic               clk;
    logic               rst;
    logic [N-1:0]       inData;
    logic               inSelect;
    logic               inValid;
    logic               inReady;
    logic [N-1:0]       zeroData;
    logic               zeroValid;
    logic               zeroReady;
    logic [N-1:0]       oneData;
    logic               oneValid;
    logic               oneReady;
    logic [COUNT_W-1:0] zeroCount;
    logic [COUNT_W-1:0] oneCount;

    int checks;
    int errors;

    // Scoreboard: words accepted per port but not yet delivered, plus expected counts.
    logic [N-1:0]       q0[$];
    logic [N-1:0]       q1[$];
    logic [COUNT_W-1:0] cnt0_m;
    logic [COUNT_W-1:0] cnt1_m;
    logic               exp_ready;

    stream_demux_1to2 #(
        .N       (N),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inData    (inData),
        .inSelect  (inSelect),
        .inValid   (inValid),
        .inReady   (inReady),
        .zeroData  (zeroData),
        .zeroValid (zeroValid),
        .zeroReady (zeroReady),
        .oneData   (oneData),
        .oneValid  (oneValid),
        .oneReady  (oneReady),
        .zeroCount (zeroCount),
        .oneCount  (oneCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs against the scoreboard at the falling edge, apply the
    // expected handshake/accept for the coming rising edge, then return 1 time unit after it.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            cnt0_m = '0;
            cnt1_m = '0;
        end else begin
            exp_ready = inSelect ? ((q1.size() == 0) || oneReady)
                                 : ((q0.size() == 0) || zeroReady);
            chk("in_ready", {31'b0, inReady}, {31'b0, exp_ready});
            chk("zero_valid", {31'b0, zeroValid}, {31'b0, q0.size() != 0});
            chk("one_valid", {31'b0, oneValid}, {31'b0, q1.size() != 0});
            chk("zero_count", 32'(zeroCount), 32'(cnt0_m));
            chk("one_count", 32'(oneCount), 32'(cnt1_m));
            if (q0.size() != 0) chk("zero_data", zeroData, q0[0]);
            if (q1.size() != 0) chk("one_data", oneData, q1[0]);
            if ((q0.size() != 0) && zeroReady) begin
                void'(q0.pop_front());
                cnt0_m = cnt0_m + 1'b1;
            end
            if ((q1.size() != 0) && oneReady) begin
                void'(q1.pop_front());
                cnt1_m = cnt1_m + 1'b1;
            end
            if (inValid && exp_ready) begin
                if (inSelect) q1.push_back(inData);
                else          q0.push_back(inData);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cnt0_m    = '0;
        cnt1_m    = '0;
        rst       = 1'b1;
        inData    = '0;
        inSelect  = 1'b0;
        inValid   = 1'b0;
        zeroReady = 1'b1;
        oneReady  = 1'b1;

        // Reset then idle.
        #12;
        chk("rst_zero_valid", {31'b0, zeroValid}, 32'd0);
        chk("rst_one_valid", {31'b0, oneValid}, 32'd0);
        chk("rst_zero_data", zeroData, 32'd0);
        chk("rst_one_data", oneData, 32'd0);
        chk("rst_zero_count", 32'(zeroCount), 32'd0);
        chk("rst_one_count", 32'(oneCount), 32'd0);
        chk("rst_in_ready", {31'b0, inReady}, 32'd1);
        step();
        rst = 1'b0;
        step();

        // Basic routing to each port, then drain both.
        zeroReady = 1'b0;
        oneReady  = 1'b0;
        inValid   = 1'b1;
        inSelect  = 1'b0;
        inData    = 32'd5;
        step();
        inValid = 1'b0;
        chk("basic_zero_valid", {31'b0, zeroValid}, 32'd1);
        chk("basic_zero_data", zeroData, 32'd5);
        chk("basic_one_valid", {31'b0, oneValid}, 32'd0);
        inValid  = 1'b1;
        inSelect = 1'b1;
        inData   = 32'd55;
        step();
        inValid = 1'b0;
        chk("basic_one_data", oneData, 32'd55);
        zeroReady = 1'b1;
        oneReady  = 1'b1;
        step();
        chk("basic_zero_count", 32'(zeroCount), 32'd1);
        chk("basic_one_count", 32'(oneCount), 32'd1);

        // Backpressure isolation.
        zeroReady = 1'b0;
        oneReady  = 1'b0;
        inValid   = 1'b1;
        inSelect  = 1'b0;
        inData    = 32'd3;
        step();
        chk("bp_zero_data", zeroData, 32'd3);
        inData = 32'd4;
        #1;
        chk("bp_blocked_ready", {31'b0, inReady}, 32'd0);
        step();
        chk("bp_zero_still_3", zeroData, 32'd3);
        inSelect = 1'b1;
        inData   = 32'd354;
        #1;
        chk("bp_other_ready", {31'b0, inReady}, 32'd1);
        step();
        chk("bp_one_data", oneData, 32'd354);
        inSelect  = 1'b0;
        inData    = 32'd4;
        zeroReady = 1'b1;
        step();
        inValid = 1'b0;
        chk("bp_zero_held_word", zeroData, 32'd4);
        chk("bp_zero_held_valid", {31'b0, zeroValid}, 32'd1);
        step();
        oneReady = 1'b1;
        step();
        step();

        // Streaming: alternate ports, both consumers always ready.
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            inValid  = 1'b1;
            inSelect = i[0];
            inData   = i;
            #1;
            chk("stream_ready", {31'b0, inReady}, 32'd1);
            step();
        end
        inValid = 1'b0;
        step();
        step();
        chk("stream_zero_count", 32'(zeroCount), 32'd10);
        chk("stream_one_count", 32'(oneCount), 32'd10);

        // Counter wrap on a 4-bit counter.
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            inValid  = 1'b1;
            inSelect = 1'b1;
            inData   = 32'h100 + i;
            step();
        end
        inValid = 1'b0;
        step();
        step();
        chk("wrap_one_count", 32'(oneCount), 32'd1);
        chk("wrap_zero_count", 32'(zeroCount), 32'd0);

        // Reset mid-operation with both slots full and stalled.
        zeroReady = 1'b0;
        oneReady  = 1'b0;
        inValid   = 1'b1;
        inSelect  = 1'b0;
        inData    = 32'hAA;
        step();
        inSelect = 1'b1;
        inData   = 32'hBB;
        step();
        inValid = 1'b0;
        chk("mid_pre_zero_valid", {31'b0, zeroValid}, 32'd1);
        chk("mid_pre_one_valid", {31'b0, oneValid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_zero_valid", {31'b0, zeroValid}, 32'd0);
        chk("mid_one_valid", {31'b0, oneValid}, 32'd0);
        chk("mid_zero_data", zeroData, 32'd0);
        chk("mid_one_data", oneData, 32'd0);
        chk("mid_one_count", 32'(oneCount), 32'd0);
        step();
        step();
        rst       = 1'b0;
        zeroReady = 1'b1;
        oneReady  = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("mid_post_zero_count", 32'(zeroCount), 32'd0);
        chk("mid_post_one_count", 32'(oneCount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
